// File: rtl/m_serial_halfsub.sv
// Bit-serial subtractor: a-b one bit per clock, LSB first, with final borrow.
// Optional M_SERIAL_HALFSUB_SATURATE_EN clamps diff to 0 on borrow.
module m_serial_halfsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_diff_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_bw;
  logic             w_d;
  logic             w_bw_nxt;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);

  assign w_d      = r_sa[0] ^ r_sb[0] ^ r_bw;
  assign w_bw_nxt = (~r_sa[0] & r_sb[0])
                  | (~(r_sa[0] ^ r_sb[0]) & r_bw);

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res_nxt = w_d;
    end else begin : g_wn
      assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

`ifdef M_SERIAL_HALFSUB_SATURATE_EN
  assign w_diff_nxt = w_bw_nxt ? '0 : w_res_nxt;
`else
  assign w_diff_nxt = w_res_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // diff/borrow are loaded on the last shift edge so they are valid with done
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_bw   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (w_accept) begin
      r_sa  <= a;
      r_sb  <= b;
      r_res <= '0;
      r_cnt <= '0;
      r_bw  <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_res <= w_res_nxt;
      r_bw  <= w_bw_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        diff   <= w_diff_nxt;
        borrow <= w_bw_nxt;
      end
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state == S_SHIFT);
  assign done  = (r_state == S_DONE);

endmodule
